icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_array.sv | 46 ++++
 rtl/icache.sv | 131 +++++++++++++
 tb/tb_icache.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: widths, FSM states
// and address helpers.
package icache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_REQ  = 2'd2,
        MISS_WAIT = 2'd3
    } state_e;

    function automatic logic [ADDR_WIDTH-1:0] word_align(
        input logic [ADDR_WIDTH-1:0] a
    );
        return a & ~ADDR_WIDTH'(3);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line store: per-line valid bit (reset), tag and data
// (no reset). Combinational read, synchronous write.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] windex,
    input  logic [TAG_BITS-1:0]   wtag,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [INDEX_BITS-1:0] rindex,
    output logic                  rvalid,
    output logic [TAG_BITS-1:0]   rtag,
    output logic [WORD_WIDTH-1:0] rdata
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [WORD_WIDTH-1:0] data_q [LINES];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[windex] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_q[windex]  <= wtag;
            data_q[windex] <= wdata;
        end
    end

    assign rvalid = valid_q[rindex];
    assign rtag   = tag_q[rindex];
    assign rdata  = data_q[rindex];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache between the fetch
// stage and the memory controller.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  IF2iCache_valid,
    input  logic [ADDR_WIDTH-1:0] IF2iCache_addr,
    output logic                  iCache2IF_ready,
    output logic                  iCache2IF_valid,
    output logic [WORD_WIDTH-1:0] iCache2IF_inst,
    output logic                  iCache2memCon_valid,
    output logic [ADDR_WIDTH-1:0] iCache2memCon_address,
    input  logic                  memCon2iCache_ifbusy,
    input  logic                  memCon2iCache_valid,
    input  logic [WORD_WIDTH-1:0] memCon2iCache_return
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  discard_q, discard_d;
    logic                  resp_q, resp_d;
    logic [WORD_WIDTH-1:0] inst_q, inst_d;
    logic                  fill_we;

    logic                  line_valid;
    logic [TAG_BITS-1:0]   line_tag;
    logic [WORD_WIDTH-1:0] line_data;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;

    assign index = addr_q[INDEX_BITS+1:2];
    assign tag   = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit   = line_valid && (line_tag == tag);

    icache_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .we    (fill_we && rdy_in),
        .windex(index),
        .wtag  (tag),
        .wdata (memCon2iCache_return),
        .rindex(index),
        .rvalid(line_valid),
        .rtag  (line_tag),
        .rdata (line_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        resp_d    = 1'b0;
        inst_d    = inst_q;
        fill_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (IF2iCache_valid && !flush_in) begin
                    addr_d  = IF2iCache_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (flush_in) begin
                    state_d = IDLE;
                end else if (hit) begin
                    resp_d  = 1'b1;
                    inst_d  = line_data;
                    state_d = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (flush_in) begin
                    state_d = IDLE;
                end else if (!memCon2iCache_ifbusy) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                // A flushed miss still fills the line; only the reply is dropped
                if (memCon2iCache_valid) begin
                    fill_we   = 1'b1;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                    if (!discard_q && !flush_in) begin
                        resp_d = 1'b1;
                        inst_d = memCon2iCache_return;
                    end
                end else if (flush_in) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            discard_q <= 1'b0;
            resp_q    <= 1'b0;
            inst_q    <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            resp_q    <= resp_d;
            inst_q    <= inst_d;
        end
    end

    assign iCache2IF_ready       = (state_q == IDLE);
    assign iCache2IF_valid       = resp_q;
    assign iCache2IF_inst        = inst_q;
    assign iCache2memCon_valid   = (state_q == MISS_REQ);
    assign iCache2memCon_address = word_align(addr_q);

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a line-table
// reference model.
module tb_icache;

    localparam int IB = 6;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_busy;
    logic        mem_valid;
    logic [31:0] mem_ret;

    int checks   = 0;
    int failures = 0;

    bit          mv [1<<IB];
    logic [23:0] mt [1<<IB];
    logic [31:0] md [1<<IB];

    icache #(.INDEX_BITS(IB)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .rdy_in               (rdy_in),
        .flush_in             (flush_in),
        .IF2iCache_valid      (if_valid),
        .IF2iCache_addr       (if_addr),
        .iCache2IF_ready      (ready),
        .iCache2IF_valid      (resp_valid),
        .iCache2IF_inst       (resp_inst),
        .iCache2memCon_valid  (mem_req),
        .iCache2memCon_address(mem_addr),
        .memCon2iCache_ifbusy (mem_busy),
        .memCon2iCache_valid  (mem_valid),
        .memCon2iCache_return (mem_ret)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        int i = int'((a >> 2) % (1 << IB));
        return mv[i] && (mt[i] == 24'(a >> (IB + 2)));
    endfunction

    // mode: 0 plain, 1 flush in LOOKUP, 2 flush in MISS_WAIT, 3 rdy stall
    task automatic fetch(input logic [31:0] a, input logic [31:0] fill,
                         input int busy, input int mode);
        int  i   = int'((a >> 2) % (1 << IB));
        bit  hit = model_hit(a);
        @(negedge clk_in);
        chk("ready_idle", {31'd0, ready}, 32'd1);
        if_valid = 1'b1;
        if_addr  = a;
        @(negedge clk_in);
        if_valid = 1'b0;
        if_addr  = $urandom;
        chk("ready_lookup", {31'd0, ready}, 32'd0);
        if (mode == 1) begin
            flush_in = 1'b1;
            @(negedge clk_in);
            flush_in = 1'b0;
            chk("flush_lookup_valid", {31'd0, resp_valid}, 32'd0);
            chk("flush_lookup_ready", {31'd0, ready}, 32'd1);
            chk("flush_lookup_req", {31'd0, mem_req}, 32'd0);
            return;
        end
        if (mode == 3) begin
            rdy_in = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk_in);
                chk("stall_valid", {31'd0, resp_valid}, 32'd0);
                chk("stall_ready", {31'd0, ready}, 32'd0);
                chk("stall_req", {31'd0, mem_req}, 32'd0);
            end
            rdy_in = 1'b1;
        end
        @(negedge clk_in);
        if (hit) begin
            chk("hit_valid", {31'd0, resp_valid}, 32'd1);
            chk("hit_inst", resp_inst, md[i]);
            chk("hit_no_req", {31'd0, mem_req}, 32'd0);
            @(negedge clk_in);
            chk("hit_pulse_end", {31'd0, resp_valid}, 32'd0);
            return;
        end
        chk("miss_no_resp", {31'd0, resp_valid}, 32'd0);
        for (int k = 0; k <= busy; k++) begin
            chk("miss_req", {31'd0, mem_req}, 32'd1);
            chk("miss_addr", mem_addr, a & 32'hFFFF_FFFC);
            mem_busy = (k < busy);
            @(negedge clk_in);
        end
        mem_busy = 1'b0;
        chk("wait_req_low", {31'd0, mem_req}, 32'd0);
        if (mode == 2) begin
            flush_in = 1'b1;
            @(negedge clk_in);
            flush_in = 1'b0;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk_in);
        mem_valid = 1'b1;
        mem_ret   = fill;
        @(negedge clk_in);
        mem_valid = 1'b0;
        mem_ret   = $urandom;
        mv[i] = 1'b1;
        mt[i] = 24'(a >> (IB + 2));
        md[i] = fill;
        chk("fill_valid", {31'd0, resp_valid}, (mode == 2) ? 32'd0 : 32'd1);
        if (mode != 2) chk("fill_inst", resp_inst, fill);
        chk("fill_ready", {31'd0, ready}, 32'd1);
        @(negedge clk_in);
        chk("fill_pulse_end", {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic stray_fill();
        @(negedge clk_in);
        mem_valid = 1'b1;
        mem_ret   = $urandom;
        @(negedge clk_in);
        mem_valid = 1'b0;
        chk("stray_valid", {31'd0, resp_valid}, 32'd0);
        chk("stray_ready", {31'd0, ready}, 32'd1);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_inst"}, resp_inst, 32'd0);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
    endtask

    task automatic reset_mid_miss(input logic [31:0] a);
        @(negedge clk_in);
        if_valid = 1'b1;
        if_addr  = a;
        @(negedge clk_in);
        if_valid = 1'b0;
        @(negedge clk_in);
        chk("rst_miss_req", {31'd0, mem_req}, 32'd1);
        mem_busy = 1'b0;
        @(negedge clk_in);
        chk("rst_wait", {31'd0, mem_req}, 32'd0);
        rst_in = 1'b0;
        #1;
        reset_outputs("rst_async");
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int k = 0; k < (1 << IB); k++) mv[k] = 1'b0;
        stray_fill();
        reset_outputs("rst_after_stray");
    endtask

    initial begin
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        flush_in  = 1'b0;
        if_valid  = 1'b0;
        if_addr   = '0;
        mem_busy  = 1'b0;
        mem_valid = 1'b0;
        mem_ret   = '0;
        for (int k = 0; k < (1 << IB); k++) mv[k] = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_outputs("reset");
        rst_in = 1'b1;

        fetch(32'h0000_0100, 32'h0050_0093, 0, 0);
        fetch(32'h0000_0100, 32'h1234_5678, 0, 0);
        fetch(32'h0000_0200, 32'h1111_1111, 0, 0);
        fetch(32'h0000_0102, 32'h0050_0093, 0, 0);
        fetch(32'h0000_0300, 32'h2222_2222, 5, 0);
        fetch(32'h0000_0400, 32'hDEAD_BEEF, 0, 2);
        fetch(32'h0000_0400, 32'h0000_0000, 0, 0);
        fetch(32'h0000_0400, 32'h0000_0000, 0, 3);
        stray_fill();
        reset_mid_miss(32'h0000_0500);
        fetch(32'h0000_0100, 32'h3333_3333, 1, 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                stray_fill();
            end else begin
                logic [31:0] a;
                int          m;
                a = (32'($urandom_range(0, 3)) << 8) |
                    (32'($urandom_range(0, 7)) << 2) |
                    32'($urandom_range(0, 3));
                m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                fetch(a, $urandom, int'($urandom_range(0, 3)), m);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
